// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selection tables, per-round shift amounts,
// and the sequencer state encoding.
package des_pkg;

  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 56;

  // Entries are used directly as key_in bit indices.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Value 1 selects the C/D MSB.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Round numbers are 1-based; anything outside 1..16 yields no rotation.
  function automatic int shift_of(input int r);
    if (r >= 1 && r <= 16) return SHIFTS[r-1];
    return 0;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit C/D pair into a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_sel
    assign subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on key accept, then one PC-2 subkey per output handshake
// in encrypt (K1 up) or decrypt (K16 down) order. Optional key parity flag: DES_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [63:0]         key_in,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic                decrypt,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [IDX_W-1:0]    round_idx,
  output logic                busy,
  output logic                done
`ifdef DES_PARITY_CHECK_EN
  ,
  output logic                parity_err
`endif
);

  state_t                state, state_nx;
  logic [CD_W-1:0]       pc1_cd, cd, cd_nx;
  logic [SUBKEY_W-1:0]   subkey_nx;
  logic [IDX_W-1:0]      idx_nx;
  logic                  dec_q;
  logic                  key_acc, sub_acc, last, load;

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign pc1_cd[CD_W-1-i] = key_in[PC1[i]];
  end

  // C (upper 28) and D (lower 28) rotate independently.
  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] v, input int n);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (n == 1) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end else if (n == 2) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end
    return {c, d};
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] v, input int n);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (n == 1) begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end else if (n == 2) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end
    return {c, d};
  endfunction

  assign key_acc = (state == IDLE) && key_valid;
  assign sub_acc = (state == RUN) && subkey_ready;
  assign last    = (round_idx == IDX_W'(ROUNDS-1));
  assign load    = key_acc || (sub_acc && !last);

  always_comb begin
    state_nx = state;
    cd_nx    = cd;
    idx_nx   = round_idx;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_nx = RUN;
          // Decrypt starts from CD16, which equals the unrotated PC-1 output.
          cd_nx    = decrypt ? pc1_cd : rotl(pc1_cd, shift_of(1));
          idx_nx   = '0;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (last) begin
            state_nx = DONE;
          end else begin
            cd_nx  = dec_q ? rotr(cd, shift_of(16 - int'(round_idx)))
                           : rotl(cd, shift_of(int'(round_idx) + 2));
            idx_nx = round_idx + 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd     (cd_nx),
    .subkey (subkey_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cd        <= '0;
      subkey    <= '0;
      round_idx <= '0;
      dec_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cd        <= cd_nx;
      round_idx <= idx_nx;
      if (key_acc) dec_q  <= decrypt;
      if (load)    subkey <= subkey_nx;
    end
  end

  assign key_ready    = (state == IDLE);
  assign busy         = (state == RUN);
  assign subkey_valid = (state == RUN);
  assign done         = (state == DONE);

`ifdef DES_PARITY_CHECK_EN
  // DES keys use odd parity per byte; any even-parity byte flags the key.
  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad |= ~(^k[8*b +: 8]);
    return bad;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       parity_err <= 1'b0;
    else if (key_acc) parity_err <= parity_bad(key_in);
  end
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key_in[0], key_in[8], key_in[16], key_in[24],
                                key_in[32], key_in[40], key_in[48], key_in[56]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: scoreboard of expected subkeys from an
// independent cumulative-shift key-schedule model, plus a ROUNDS=4 instance.
module tb_des_key_schedule;

  localparam int TPC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TPC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TSH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        key_valid, decrypt, subkey_ready;
  logic        key_ready, subkey_valid, busy, done;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        key_valid4, subkey_ready4;
  logic        key_ready4, subkey_valid4, busy4, done4;
  logic [47:0] subkey4;
  logic [1:0]  round_idx4;
`ifdef DES_PARITY_CHECK_EN
  logic        parity_err, parity_err4;
`endif

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .decrypt(decrypt), .subkey(subkey), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .round_idx(round_idx), .busy(busy), .done(done)
`ifdef DES_PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  des_key_schedule #(.ROUNDS(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid4), .key_ready(key_ready4),
    .decrypt(decrypt), .subkey(subkey4), .subkey_valid(subkey_valid4),
    .subkey_ready(subkey_ready4), .round_idx(round_idx4), .busy(busy4), .done(done4)
`ifdef DES_PARITY_CHECK_EN
    , .parity_err(parity_err4)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [51:0] q[$];
  logic [47:0] mk [16];
  logic [47:0] obs [16];
  logic [47:0] enc_obs [16];

  // Model: C_r/D_r by cumulative left shifts from the PC-1 output, K_r = PC2(C_r D_r).
  task automatic compute_model(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks;
    for (int i = 0; i < 56; i++) cd[6'(55-i)] = k[6'(TPC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < TSH[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[6'(47-i)] = cd[6'(56-TPC2[i])];
      mk[r] = ks;
    end
  endtask

  task automatic push_expected(input logic dec, input int rounds);
    for (int j = 0; j < rounds; j++)
      q.push_back({4'(j), dec ? mk[15-j] : mk[j]});
  endtask

  task automatic run_key(input logic [63:0] k, input logic dec, input int stall_at, input logic poke);
    int          iters;
    int          stall;
    logic [47:0] hold_k;
    logic [3:0]  hold_i;
    logic [51:0] exp_e;
    iters = 0;
    stall = 0;
    hold_k = '0;
    hold_i = '0;
    compute_model(k);
    q.delete();
    push_expected(dec, 16);
    @(negedge clk);
    key_in = k; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b1;
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL key_ready_idle: got %b want 1", key_ready); end
    @(negedge clk);
    key_valid = 1'b0; decrypt = ~dec;
    while (q.size() > 0 && iters < 60) begin
      iters++;
      if (poke && iters == 3) begin
        key_valid = 1'b1; key_in = ~k;
        checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL ready_in_run: key_ready=%b busy=%b want 0/1", key_ready, busy);
        end
      end else key_valid = 1'b0;
      if (stall_at >= 0 && round_idx == 4'(stall_at) && stall < 3) begin
        if (stall == 0) begin
          hold_k = subkey; hold_i = round_idx;
        end else begin
          checks++;
          if ({subkey, round_idx} !== {hold_k, hold_i}) begin
            errors++;
            $display("FAIL stall_hold: got %h/%0d want %h/%0d", subkey, round_idx, hold_k, hold_i);
          end
        end
        stall++;
        subkey_ready = 1'b0;
      end else subkey_ready = 1'b1;
      checks++;
      if (subkey_valid !== 1'b1) begin
        errors++; $display("FAIL subkey_valid: got %b want 1 (iter %0d)", subkey_valid, iters);
      end else if (subkey_ready) begin
        exp_e = q.pop_front();
        checks++;
        if ({round_idx, subkey} !== exp_e) begin
          errors++;
          $display("FAIL subkey: got idx %0d key %h want idx %0d key %h",
                   round_idx, subkey, exp_e[51:48], exp_e[47:0]);
        end
        obs[round_idx] = subkey;
      end
      @(negedge clk);
    end
    key_valid = 1'b0;
    subkey_ready = 1'b1;
    checks++;
    if (q.size() != 0 || iters != 16 + stall) begin
      errors++; $display("FAIL throughput: iters %0d left %0d want iters %0d left 0", iters, q.size(), 16 + stall);
    end
    checks++;
    if ({done, subkey_valid, key_ready, busy} !== 4'b1000) begin
      errors++; $display("FAIL done_cycle: done/valid/ready/busy=%b want 1000", {done, subkey_valid, key_ready, busy});
    end
    @(negedge clk);
    checks++;
    if ({done, key_ready} !== 2'b01) begin
      errors++; $display("FAIL after_done: done/ready=%b want 01", {done, key_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1;
    key_valid4 = 1'b0; subkey_ready4 = 1'b1;
    #1;
    checks++;
    if ({subkey, subkey_valid, round_idx, busy, done, key_ready} !== {48'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset: key %h valid %b idx %0d busy %b done %b ready %b",
                         subkey, subkey_valid, round_idx, busy, done, key_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_key();
    run_key(64'h0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs[i] !== 48'h0) begin errors++; $display("FAIL zero_key[%0d]: got %h want 0", i, obs[i]); end
    end
  endtask

  task automatic test_ones_key();
    for (int m = 0; m < 2; m++) begin
      run_key(64'hFFFF_FFFF_FFFF_FFFF, m[0], -1, 1'b0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs[i] !== 48'hFFFF_FFFF_FFFF) begin
          errors++; $display("FAIL ones_key m%0d[%0d]: got %h want ffffffffffff", m, i, obs[i]);
        end
      end
    end
  endtask

  // Classic vector 133457799BBCDFF1 remapped so key_in[n] holds FIPS key bit n.
  task automatic test_known_answer();
    logic [63:0] kf, kp;
    kf = 64'h1334_5779_9BBC_DFF1;
    kp = '0;
    for (int n = 1; n < 64; n++) kp[6'(n)] = kf[6'(64-n)];
    run_key(kp, 1'b0, -1, 1'b0);
    checks++;
    if (obs[0] !== 48'h1B02_EFFC_7072) begin errors++; $display("FAIL kat_k1: got %h want 1b02effc7072", obs[0]); end
    run_key(kp, 1'b1, -1, 1'b0);
    checks++;
    if (obs[0] !== 48'hCB3D_8B0E_17F5) begin errors++; $display("FAIL kat_k16: got %h want cb3d8b0e17f5", obs[0]); end
  endtask

  task automatic test_random_keys();
    logic [63:0] k;
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom()};
      run_key(k, 1'b0, -1, 1'b0);
      for (int i = 0; i < 16; i++) enc_obs[i] = obs[i];
      run_key(k, 1'b1, -1, 1'b0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs[i] !== enc_obs[15-i]) begin
          errors++; $display("FAIL dec_reverse[%0d]: got %h want %h", i, obs[i], enc_obs[15-i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_key({$urandom(), $urandom()}, 1'b0, 5, 1'b0);
    run_key({$urandom(), $urandom()}, 1'b1, 5, 1'b0);
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    @(negedge clk);
    key_in = 64'h0123_4567_89AB_CDEF; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    while (round_idx != 4'd7 && n < 30) begin n++; @(negedge clk); end
    checks++;
    if (round_idx !== 4'd7) begin errors++; $display("FAIL abort_reach7: got %0d want 7", round_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({subkey, subkey_valid, round_idx, busy, done, key_ready} !== {48'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL abort_reset: key %h valid %b idx %0d busy %b done %b ready %b",
                         subkey, subkey_valid, round_idx, busy, done, key_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (subkey_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort_quiet: valid %b done %b want 0/0", subkey_valid, done);
      end
    end
    run_key(64'hFEDC_BA98_7654_3210, 1'b1, -1, 1'b1);
  endtask

  task automatic test_rounds4();
    logic [51:0] exp_e;
    int          n;
    for (int m = 0; m < 2; m++) begin
      n = 0;
      key_in = {$urandom(), $urandom()};
      compute_model(key_in);
      q.delete();
      push_expected(m[0], 4);
      @(negedge clk);
      decrypt = m[0]; key_valid4 = 1'b1; subkey_ready4 = 1'b1;
      @(negedge clk);
      key_valid4 = 1'b0;
      while (q.size() > 0 && n < 20) begin
        n++;
        exp_e = q.pop_front();
        checks++;
        if ({subkey_valid4, round_idx4, subkey4} !== {1'b1, exp_e[49:48], exp_e[47:0]}) begin
          errors++;
          $display("FAIL r4_subkey m%0d: got v%b idx %0d key %h want idx %0d key %h",
                   m, subkey_valid4, round_idx4, subkey4, exp_e[49:48], exp_e[47:0]);
        end
        @(negedge clk);
      end
      checks++;
      if ({done4, subkey_valid4} !== 2'b10) begin
        errors++; $display("FAIL r4_done m%0d: done/valid=%b want 10", m, {done4, subkey_valid4});
      end
      @(negedge clk);
    end
  endtask

`ifdef DES_PARITY_CHECK_EN
  task automatic test_parity();
    run_key(64'h0101_0101_0101_0101, 1'b0, -1, 1'b0);
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_odd: got %b want 0", parity_err); end
    run_key(64'h0, 1'b0, -1, 1'b0);
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_even: got %b want 1", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_ones_key();
    test_known_answer();
    test_random_keys();
    test_backpressure();
    test_abort();
    test_rounds4();
`ifdef DES_PARITY_CHECK_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
